// File: rtl/serial_adder_pkg.sv
// serial_adder_pkg: shared types and defaults for the bit-serial adder.
// Revision: 1.0
`default_nettype none

package serial_adder_pkg;

  localparam int DEFAULT_WIDTH = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage : serial_adder_pkg

`default_nettype wire

// File: rtl/full_adder.sv
// full_adder: combinational one-bit adder cell, reused for every bit position.
// Revision: 1.0
`default_nettype none

module full_adder (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic s,
  output logic cout
);

  logic w_half;

  assign w_half = a ^ b;
  assign s      = w_half ^ cin;
  assign cout   = (a & b) | (cin & w_half);

endmodule : full_adder

`default_nettype wire

// File: rtl/serial_adder.sv
// serial_adder: LSB-first bit-serial adder, one bit per clock through a single
// full_adder cell, with valid/ready on both operand and result sides. Revision: 1.0
`default_nettype none

module serial_adder
  import serial_adder_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start_valid,
  output logic             start_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             carry_in,
  output logic             result_valid,
  input  logic             result_ready,
  output logic [WIDTH-1:0] sum,
  output logic             carry_out,
  output logic             overflow
);

  // One extra bit so the counter can step past WIDTH-1 without wrapping.
  localparam int                CNT_W    = $clog2(WIDTH) + 1;
  localparam logic [CNT_W-1:0]  LAST_BIT = CNT_W'(WIDTH - 1);

  state_t             state_q;
  logic [WIDTH-1:0]   a_sh_q;
  logic [WIDTH-1:0]   b_sh_q;
  logic [WIDTH-1:0]   acc_q;
  logic               carry_q;
  logic [CNT_W-1:0]   cnt_q;
  logic               start_ready_q;
  logic               result_valid_q;
  logic [WIDTH-1:0]   sum_q;
  logic               cout_q;
  logic               ovf_q;

  logic               fa_s;
  logic               fa_cout;
  logic [WIDTH-1:0]   a_sh_d;
  logic [WIDTH-1:0]   b_sh_d;
  logic [WIDTH-1:0]   acc_d;

  full_adder u_cell (
    .a    (a_sh_q[0]),
    .b    (b_sh_q[0]),
    .cin  (carry_q),
    .s    (fa_s),
    .cout (fa_cout)
  );

  assign a_sh_d = a_sh_q >> 1;
  assign b_sh_d = b_sh_q >> 1;
  // New sum bit enters at the MSB so bit 0 ends up at position 0 after WIDTH shifts.
  assign acc_d  = WIDTH'({fa_s, acc_q} >> 1);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q        <= IDLE;
      a_sh_q         <= '0;
      b_sh_q         <= '0;
      acc_q          <= '0;
      carry_q        <= 1'b0;
      cnt_q          <= '0;
      start_ready_q  <= 1'b1;
      result_valid_q <= 1'b0;
      sum_q          <= '0;
      cout_q         <= 1'b0;
      ovf_q          <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (start_valid) begin
            a_sh_q        <= a;
            b_sh_q        <= b;
            carry_q       <= carry_in;
            acc_q         <= '0;
            cnt_q         <= '0;
            start_ready_q <= 1'b0;
            state_q       <= RUN;
          end
        end
        RUN: begin
          a_sh_q  <= a_sh_d;
          b_sh_q  <= b_sh_d;
          acc_q   <= acc_d;
          carry_q <= fa_cout;
          cnt_q   <= cnt_q + 1'b1;
          if (cnt_q == LAST_BIT) begin
            // carry_q here is the carry into the MSB.
            sum_q          <= acc_d;
            cout_q         <= fa_cout;
            ovf_q          <= carry_q ^ fa_cout;
            result_valid_q <= 1'b1;
            state_q        <= DONE;
          end
        end
        DONE: begin
          if (result_ready) begin
            result_valid_q <= 1'b0;
            start_ready_q  <= 1'b1;
            state_q        <= IDLE;
          end
        end
        default: begin
          result_valid_q <= 1'b0;
          start_ready_q  <= 1'b1;
          state_q        <= IDLE;
        end
      endcase
    end
  end

  assign start_ready  = start_ready_q;
  assign result_valid = result_valid_q;
  assign sum          = sum_q;
  assign carry_out    = cout_q;
  assign overflow     = ovf_q;

endmodule : serial_adder

`default_nettype wire

// File: tb/tb_serial_adder.sv
// tb_serial_adder: randomized self-checking bench for serial_adder at WIDTH=8 and WIDTH=1.
// Revision: 1.0
`default_nettype none

module tb_serial_adder;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic       sv8, sr8, rr8, rv8, cin8, co8, ov8;
  logic [7:0] a8, b8, s8;
  logic       sv1, sr1, rr1, rv1, cin1, co1, ov1;
  logic [0:0] a1, b1, s1;

  int checks   = 0;
  int failures = 0;

  serial_adder #(.WIDTH(8)) u_dut8 (
    .clk(clk), .rst(rst),
    .start_valid(sv8), .start_ready(sr8),
    .a(a8), .b(b8), .carry_in(cin8),
    .result_valid(rv8), .result_ready(rr8),
    .sum(s8), .carry_out(co8), .overflow(ov8)
  );

  serial_adder #(.WIDTH(1)) u_dut1 (
    .clk(clk), .rst(rst),
    .start_valid(sv1), .start_ready(sr1),
    .a(a1), .b(b1), .carry_in(cin1),
    .result_valid(rv1), .result_ready(rr1),
    .sum(s1), .carry_out(co1), .overflow(ov1)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic drive(input int sel, input logic sv, input logic [63:0] a, input logic [63:0] b,
                       input logic cin, input logic rr);
    if (sel == 1) begin
      sv1 = sv; a1 = a[0:0]; b1 = b[0:0]; cin1 = cin; rr1 = rr;
    end else begin
      sv8 = sv; a8 = a[7:0]; b8 = b[7:0]; cin8 = cin; rr8 = rr;
    end
  endtask

  task automatic sample(input int sel, output logic rv, output logic sr, output logic [63:0] s,
                        output logic co, output logic ov);
    if (sel == 1) begin
      rv = rv1; sr = sr1; s = {63'd0, s1}; co = co1; ov = ov1;
    end else begin
      rv = rv8; sr = sr8; s = {56'd0, s8}; co = co8; ov = ov8;
    end
  endtask

  task automatic check_reset_vals(input int sel, input string tag);
    logic rv, sr, co, ov;
    logic [63:0] s;
    sample(sel, rv, sr, s, co, ov);
    check({tag, "_start_ready"}, 64'(sr), 64'd1);
    check({tag, "_result_valid"}, 64'(rv), 64'd0);
    check({tag, "_sum"}, s, 64'd0);
    check({tag, "_carry_out"}, 64'(co), 64'd0);
    check({tag, "_overflow"}, 64'(ov), 64'd0);
  endtask

  // One full transaction; the expected result comes from integer and signed arithmetic.
  task automatic run_op(input int sel, input logic [63:0] a_in, input logic [63:0] b_in,
                        input logic cin, input int stall, input logic rr_run);
    int          w;
    int          n;
    logic [63:0] mask, a, b, tot, e_s, s;
    longint      sa, sb, ss, lim;
    logic        e_co, e_ov, rv, sr, co, ov;
    w    = (sel == 1) ? 1 : 8;
    mask = (64'd1 << w) - 64'd1;
    a    = a_in & mask;
    b    = b_in & mask;
    tot  = a + b + 64'(cin);
    e_s  = tot & mask;
    e_co = tot[w];
    lim  = longint'(1) << (w - 1);
    sa   = a[w-1] ? longint'(a) - (longint'(1) << w) : longint'(a);
    sb   = b[w-1] ? longint'(b) - (longint'(1) << w) : longint'(b);
    ss   = sa + sb + longint'(cin);
    e_ov = (ss > lim - 1) || (ss < -lim);

    n = 0;
    sample(sel, rv, sr, s, co, ov);
    while (!sr && n < 50) begin
      @(posedge clk); #1; n++;
      sample(sel, rv, sr, s, co, ov);
    end
    check("start_ready_idle", 64'(sr), 64'd1);

    drive(sel, 1'b1, a, b, cin, 1'b0);
    @(posedge clk); #1;
    // Scramble operands after acceptance; the DUT must ignore them.
    drive(sel, 1'b0, {32'd0, $urandom}, {32'd0, $urandom}, 1'($urandom_range(1)), rr_run);
    sample(sel, rv, sr, s, co, ov);
    check("start_ready_busy", 64'(sr), 64'd0);

    n  = 0;
    rv = 1'b0;
    while (!rv && n < 200) begin
      @(posedge clk); #1; n++;
      sample(sel, rv, sr, s, co, ov);
    end
    drive(sel, 1'b0, a, b, cin, 1'b0);
    check("latency", 64'(n), 64'(w));
    check("sum", s, e_s);
    check("carry_out", 64'(co), 64'(e_co));
    check("overflow", 64'(ov), 64'(e_ov));

    for (int i = 0; i < stall; i++) begin
      drive(sel, 1'b1, {32'd0, $urandom}, {32'd0, $urandom}, 1'($urandom_range(1)), 1'b0);
      @(posedge clk); #1;
      sample(sel, rv, sr, s, co, ov);
      check("hold_valid", 64'(rv), 64'd1);
      check("hold_start_ready", 64'(sr), 64'd0);
      check("hold_sum", s, e_s);
      check("hold_flags", {62'd0, co, ov}, {62'd0, e_co, e_ov});
    end

    drive(sel, 1'b0, a, b, cin, 1'b1);
    @(posedge clk); #1;
    drive(sel, 1'b0, a, b, cin, 1'b0);
    sample(sel, rv, sr, s, co, ov);
    check("release_valid", 64'(rv), 64'd0);
    check("release_start_ready", 64'(sr), 64'd1);
    check("idle_sum", s, e_s);
    check("idle_flags", {62'd0, co, ov}, {62'd0, e_co, e_ov});
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    drive(0, 1'b0, 64'd0, 64'd0, 1'b0, 1'b0);
    drive(1, 1'b0, 64'd0, 64'd0, 1'b0, 1'b0);
    repeat (3) @(posedge clk);
    #1;
    check_reset_vals(0, "reset8");
    check_reset_vals(1, "reset1");
    rst = 1'b0;
    @(posedge clk); #1;

    run_op(0, 64'h3C, 64'h05, 1'b0, 0, 1'b1);
    run_op(0, 64'hFF, 64'h01, 1'b0, 0, 1'b1);
    run_op(0, 64'h7F, 64'h00, 1'b1, 0, 1'b1);
    run_op(0, 64'h80, 64'h80, 1'b0, 5, 1'b0);

    // Abort an operation mid-RUN with a short reset pulse between clock edges.
    drive(0, 1'b1, 64'hFF, 64'hFF, 1'b1, 1'b0);
    @(posedge clk); #1;
    drive(0, 1'b0, 64'hFF, 64'hFF, 1'b1, 1'b0);
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;
    #2;
    check_reset_vals(0, "midrun_reset8");
    #1 rst = 1'b0;
    run_op(0, 64'h01, 64'h02, 1'b0, 0, 1'b1);

    run_op(1, 64'd0, 64'd0, 1'b1, 0, 1'b1);
    run_op(1, 64'd1, 64'd0, 1'b1, 0, 1'b1);
    run_op(1, 64'd1, 64'd1, 1'b0, 2, 1'b0);

    for (int i = 0; i < 500; i++) begin
      repeat ($urandom_range(2)) @(posedge clk);
      #1;
      run_op(0, {32'd0, $urandom}, {32'd0, $urandom}, 1'($urandom_range(1)),
             int'($urandom_range(3)), 1'($urandom_range(1)));
    end
    for (int i = 0; i < 500; i++) begin
      repeat ($urandom_range(2)) @(posedge clk);
      #1;
      run_op(1, {32'd0, $urandom}, {32'd0, $urandom}, 1'($urandom_range(1)),
             int'($urandom_range(3)), 1'($urandom_range(1)));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule : tb_serial_adder

`default_nettype wire
